div_issue_sched: RTL

//  Issue/retire scheduler for the fixed-latency, fully pipelined unsigned divider (DIV/DIVU).

---
 rtl/div_issue_sched_pkg.sv | 29 ++
 rtl/div_issue_sched_if.sv | 31 +++
 rtl/div_issue_sched_rsp_fifo.sv | 79 +++++++
 rtl/div_issue_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/div_issue_sched_pkg.sv
// Shared definitions for the divider issue/retire scheduler:
// default sizing and the per-op sign/zero flags carried alongside the divider.
package div_issue_sched_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAG_W     = 5;
  localparam int DEF_LATENCY   = 16;
  localparam int DEF_BUF_DEPTH = 4;

  // Flags that travel down the stage pipe next to the tag and raw dividend.
  typedef struct packed {
    logic qneg;  // quotient must be negated at the divider output
    logic rneg;  // remainder must be negated at the divider output
    logic dz;    // divisor was zero, divider output is ignored
  } div_flags_t;

  // Fix-up flags for a request: negation only applies to signed ops.
  function automatic div_flags_t calc_flags(input logic is_signed,
                                            input logic dvd_msb,
                                            input logic dvs_msb,
                                            input logic dvs_zero);
    div_flags_t f;
    f.qneg = is_signed && (dvd_msb ^ dvs_msb);
    f.rneg = is_signed && dvd_msb;
    f.dz   = dvs_zero;
    return f;
  endfunction

endpackage

// File: rtl/div_issue_sched_if.sv
// Request/response handshake bundle between EX, the scheduler and HI/LO writeback.
interface div_issue_sched_if
  import div_issue_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_signed;
  logic [DATA_W-1:0] req_dividend;
  logic [DATA_W-1:0] req_divisor;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_quotient;
  logic [DATA_W-1:0] rsp_remainder;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_dz;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dz
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dz
  );
endinterface

// File: rtl/div_issue_sched_rsp_fifo.sv
// Response FIFO for finished divides; entries are {tag, dz, quotient, remainder}.
// Outputs come straight from storage registers, clear wipes contents to zero.
module div_issue_sched_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic              push_dz,
  input  logic [DATA_W-1:0] push_quot,
  input  logic [DATA_W-1:0] push_rem,
  input  logic              pop,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_dz,
  output logic [DATA_W-1:0] out_quot,
  output logic [DATA_W-1:0] out_rem
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic              mem_dz   [DEPTH];
  logic [DATA_W-1:0] mem_quot [DEPTH];
  logic [DATA_W-1:0] mem_rem  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_pop;

  assign out_valid = (count != '0);
  assign do_pop    = pop && out_valid;
  assign out_tag   = mem_tag[rd_ptr];
  assign out_dz    = mem_dz[rd_ptr];
  assign out_quot  = mem_quot[rd_ptr];
  assign out_rem   = mem_rem[rd_ptr];

  // Storage, wrap-around pointers and occupancy; push and pop are independent
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_tag[i]  <= '0;
        mem_dz[i]   <= 1'b0;
        mem_quot[i] <= '0;
        mem_rem[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_tag[wr_ptr]  <= push_tag;
        mem_dz[wr_ptr]   <= push_dz;
        mem_quot[wr_ptr] <= push_quot;
        mem_rem[wr_ptr]  <= push_rem;
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue credits must make a write into a full FIFO impossible
  always @(posedge clk) begin
    if (!clr) begin
      assert (!(push && !do_pop && (count == CNT_W'(DEPTH))));
    end
  end

endmodule

// File: rtl/div_issue_sched.sv
// Issue/retire scheduler for a fixed-latency pipelined unsigned divider.
// Feeds operand magnitudes to the divider, tracks ops in a valid/tag/flag pipe,
// applies signed fix-up on the divider output and credit-limits issue so the
// response FIFO can always absorb every in-flight result.
module div_issue_sched
  import div_issue_sched_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  div_issue_sched_if.slave  bus,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  output logic              busy
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic is_signed,
                                                  input logic [DATA_W-1:0] x);
    return (is_signed && x[DATA_W-1]) ? neg2c(x) : x;
  endfunction

  logic              accept;
  logic              pop;
  logic              push;
  logic              rsp_valid_int;
  logic [CNT_W-1:0]  outstanding;
  div_flags_t        req_flg;
  logic [DATA_W-1:0] fix_quot;
  logic [DATA_W-1:0] fix_rem;

  logic              vld_p [1:LATENCY];
  logic [TAG_W-1:0]  tag_p [1:LATENCY];
  div_flags_t        flg_p [1:LATENCY];
  logic [DATA_W-1:0] dvd_p [1:LATENCY];

  assign bus.req_ready = !reset && !flush && (outstanding < CNT_W'(BUF_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = rsp_valid_int && bus.rsp_ready;
  assign busy          = (outstanding != '0);
  assign bus.rsp_valid = rsp_valid_int;

  assign div_dividend = magnitude(bus.req_signed, bus.req_dividend);
  assign div_divisor  = magnitude(bus.req_signed, bus.req_divisor);
  assign req_flg      = calc_flags(bus.req_signed, bus.req_dividend[DATA_W-1],
                                   bus.req_divisor[DATA_W-1], bus.req_divisor == '0);

  // Stage pipe: payload shifts every cycle, only the valid bits see reset/flush
  always_ff @(posedge clk) begin
    tag_p[1] <= bus.req_tag;
    flg_p[1] <= req_flg;
    dvd_p[1] <= bus.req_dividend;
    for (int k = 2; k <= LATENCY; k++) begin
      tag_p[k] <= tag_p[k-1];
      flg_p[k] <= flg_p[k-1];
      dvd_p[k] <= dvd_p[k-1];
    end
    if (reset || flush) begin
      for (int k = 1; k <= LATENCY; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[1] <= accept;
      for (int k = 2; k <= LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Divider output stage: sign fix-up, divide-by-zero substitutes all-ones / dividend
  always_comb begin
    fix_quot = div_quotient;
    fix_rem  = div_remainder;
    if (flg_p[LATENCY].dz) begin
      fix_quot = '1;
      fix_rem  = dvd_p[LATENCY];
    end else begin
      if (flg_p[LATENCY].qneg) fix_quot = neg2c(div_quotient);
      if (flg_p[LATENCY].rneg) fix_rem  = neg2c(div_remainder);
    end
  end

  assign push = vld_p[LATENCY];

  // Outstanding credits: in flight plus buffered, freed only when writeback pops
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  div_issue_sched_rsp_fifo #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (BUF_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .clr       (reset || flush),
    .push      (push),
    .push_tag  (tag_p[LATENCY]),
    .push_dz   (flg_p[LATENCY].dz),
    .push_quot (fix_quot),
    .push_rem  (fix_rem),
    .pop       (bus.rsp_ready),
    .out_valid (rsp_valid_int),
    .out_tag   (bus.rsp_tag),
    .out_dz    (bus.rsp_dz),
    .out_quot  (bus.rsp_quotient),
    .out_rem   (bus.rsp_remainder)
  );

endmodule
